// File: rtl/jelly_fixed_projection_divider.sv
// jelly_fixed_projection_divider
//   Perspective-divide stage: u = x/z, v = y/z on signed fixed-point inputs.
//   Two radix-2 restoring dividers run in lock-step off one iteration counter.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk, reset (sync, active-high), cke (global clock enable)
//   s_user/s_fixed_x/s_fixed_y/s_fixed_z, s_valid/s_ready : input stream
//   m_user/m_fixed_u/m_fixed_v/m_range_error, m_valid/m_ready : result stream
//   m_range_error is set when z<=0 or either quotient saturated.
module jelly_fixed_projection_divider #(
  parameter int S_FIXED_INT_WIDTH  = 17,
  parameter int S_FIXED_FRAC_WIDTH = 8,
  parameter int S_FIXED_WIDTH      = S_FIXED_INT_WIDTH + S_FIXED_FRAC_WIDTH,
  parameter int M_FIXED_INT_WIDTH  = 12,
  parameter int M_FIXED_FRAC_WIDTH = 8,
  parameter int M_FIXED_WIDTH      = M_FIXED_INT_WIDTH + M_FIXED_FRAC_WIDTH,
  parameter int USER_WIDTH         = 0,
  parameter int USER_BITS          = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [USER_BITS-1:0]     s_user,
  input  logic [S_FIXED_WIDTH-1:0] s_fixed_x,
  input  logic [S_FIXED_WIDTH-1:0] s_fixed_y,
  input  logic [S_FIXED_WIDTH-1:0] s_fixed_z,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [USER_BITS-1:0]     m_user,
  output logic [M_FIXED_WIDTH-1:0] m_fixed_u,
  output logic [M_FIXED_WIDTH-1:0] m_fixed_v,
  output logic                     m_range_error,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int SW    = S_FIXED_WIDTH;
  localparam int MW    = M_FIXED_WIDTH;
  localparam int HI_W  = SW + M_FIXED_FRAC_WIDTH;   // dividend bits above the quotient window
  localparam int DVD_W = HI_W + MW;
  localparam int CNT_W = $clog2(MW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Symmetric saturation: the most negative code is never produced.
  localparam logic [MW-1:0] SAT_MAX = {1'b0, {(MW-1){1'b1}}};

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]        div_q, div_d;
  logic [USER_BITS-1:0] user_q, user_d;
  logic                 m_valid_q, m_valid_d;
  logic [MW-1:0]        m_u_q, m_u_d;
  logic [MW-1:0]        m_v_q, m_v_d;
  logic                 m_err_q, m_err_d;
  logic [USER_BITS-1:0] m_user_q, m_user_d;

  logic                 accept;
  logic                 z_pos;
  logic [SW-1:0]        z_abs;
  logic [1:0][MW-1:0]   lane_res;
  logic [1:0]           lane_err;

  assign s_ready = (state_q == ST_IDLE) && !reset;
  assign accept  = s_valid && s_ready && cke;
  assign z_pos   = !s_fixed_z[SW-1] && (s_fixed_z != '0);
  assign z_abs   = s_fixed_z[SW-1] ? (~s_fixed_z + 1'b1) : s_fixed_z;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [SW-1:0]    num_s;
      logic [SW-1:0]    num_abs;
      logic [DVD_W-1:0] dvd_full;
      logic [SW-1:0]    rem_q, rem_d;
      // Shift register: dividend bits leave at the top, quotient bits enter at the bottom.
      logic [MW-1:0]    qd_q, qd_d;
      logic             neg_q, neg_d;
      logic             ovf_q, ovf_d;
      logic [SW:0]      trial;
      logic             q_bit;
      logic             sat;
      logic [MW-1:0]    mag;

      assign num_s = (gi == 0) ? s_fixed_x : s_fixed_y;

      always_comb begin
        num_abs  = num_s[SW-1] ? (~num_s + 1'b1) : num_s;
        dvd_full = DVD_W'({num_abs, {M_FIXED_FRAC_WIDTH{1'b0}}});
        trial    = {rem_q, qd_q[MW-1]};
        q_bit    = (trial >= {1'b0, div_q});
        rem_d    = rem_q;
        qd_d     = qd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        if (state_q == ST_IDLE && accept) begin
          rem_d = dvd_full[MW +: SW];
          qd_d  = dvd_full[MW-1:0];
          neg_d = num_s[SW-1] ^ s_fixed_z[SW-1];
          // Quotient would need more than MW magnitude bits.
          ovf_d = (dvd_full[DVD_W-1:MW] >= HI_W'(z_abs));
        end else if (state_q == ST_CALC) begin
          // When q_bit is set the difference is below div_q, so SW bits suffice.
          rem_d = q_bit ? (trial[SW-1:0] - div_q) : trial[SW-1:0];
          qd_d  = {qd_q[MW-2:0], q_bit};
        end
        // Result as seen on the final iteration (qd_d then holds the full quotient).
        sat = ovf_q || qd_d[MW-1];
        mag = sat ? SAT_MAX : qd_d;
      end

      assign lane_res[gi] = neg_q ? (~mag + 1'b1) : mag;
      assign lane_err[gi] = sat;

      always_ff @(posedge clk) begin
        if (reset) begin
          rem_q <= '0;
          qd_q  <= '0;
          neg_q <= 1'b0;
          ovf_q <= 1'b0;
        end else if (cke) begin
          rem_q <= rem_d;
          qd_q  <= qd_d;
          neg_q <= neg_d;
          ovf_q <= ovf_d;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    user_d    = user_q;
    m_valid_d = m_valid_q;
    m_u_d     = m_u_q;
    m_v_d     = m_v_q;
    m_err_d   = m_err_q;
    m_user_d  = m_user_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          user_d = s_user;
          div_d  = z_abs;
          if (!z_pos) begin
            // Divisor not usable: report immediately.
            m_u_d     = '0;
            m_v_d     = '0;
            m_err_d   = 1'b1;
            m_user_d  = s_user;
            m_valid_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d   = CNT_W'(MW);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          m_u_d     = lane_res[0];
          m_v_d     = lane_res[1];
          m_err_d   = |lane_err;
          m_user_d  = user_q;
          m_valid_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      user_q    <= '0;
      m_valid_q <= 1'b0;
      m_u_q     <= '0;
      m_v_q     <= '0;
      m_err_q   <= 1'b0;
      m_user_q  <= '0;
    end else if (cke) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      user_q    <= user_d;
      m_valid_q <= m_valid_d;
      m_u_q     <= m_u_d;
      m_v_q     <= m_v_d;
      m_err_q   <= m_err_d;
      m_user_q  <= m_user_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_fixed_u     = m_u_q;
  assign m_fixed_v     = m_v_q;
  assign m_range_error = m_err_q;
  assign m_user        = m_user_q;

endmodule

// File: tb/tb_jelly_fixed_projection_divider.sv
// Testbench for jelly_fixed_projection_divider.
//   Stimulus pushes the model's expected result into a queue on each accept;
//   a monitor pops and compares on every output handshake.
//   Latency is counted in clock edges with the accept edge counted as 1.
module tb_jelly_fixed_projection_divider;

  localparam int SW      = 25;
  localparam int MW      = 20;
  localparam int FRAC    = 8;
  localparam int UW      = 4;
  localparam longint MAXQ = (longint'(1) << (MW - 1)) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke = 1'b1;
  logic [UW-1:0] s_user = '0;
  logic [SW-1:0] s_fixed_x = '0;
  logic [SW-1:0] s_fixed_y = '0;
  logic [SW-1:0] s_fixed_z = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [UW-1:0] m_user;
  logic [MW-1:0] m_fixed_u;
  logic [MW-1:0] m_fixed_v;
  logic          m_range_error;
  logic          m_valid;
  logic          m_ready = 1'b1;

  jelly_fixed_projection_divider #(.USER_WIDTH(UW)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_user(s_user), .s_fixed_x(s_fixed_x), .s_fixed_y(s_fixed_y), .s_fixed_z(s_fixed_z),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_user(m_user), .m_fixed_u(m_fixed_u), .m_fixed_v(m_fixed_v),
    .m_range_error(m_range_error), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] u;
    logic [MW-1:0] v;
    logic          err;
    logic [UW-1:0] user;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn_n = 0;

  // Reference: u = trunc(x*2^FRAC / z) with symmetric saturation.
  function automatic exp_t model(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                 input logic [SW-1:0] z, input logic [UW-1:0] user);
    exp_t   e;
    longint lx, ly, lz, qu, qv;
    lx = longint'($signed(x));
    ly = longint'($signed(y));
    lz = longint'($signed(z));
    e.user = user;
    e.err  = 1'b0;
    if (lz <= 0) begin
      e.u   = '0;
      e.v   = '0;
      e.err = 1'b1;
    end else begin
      qu = ((lx < 0 ? -lx : lx) * 256) / lz;
      qv = ((ly < 0 ? -ly : ly) * 256) / lz;
      if (qu > MAXQ) begin qu = MAXQ; e.err = 1'b1; end
      if (qv > MAXQ) begin qv = MAXQ; e.err = 1'b1; end
      if (lx < 0) qu = -qu;
      if (ly < 0) qv = -qv;
      e.u = qu[MW-1:0];
      e.v = qv[MW-1:0];
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: a handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (!reset && cke && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got u=%0d v=%0d err=%0b, no result expected",
                 $signed(m_fixed_u), $signed(m_fixed_v), m_range_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn_n++;
        if (m_fixed_u !== e.u || m_fixed_v !== e.v || m_range_error !== e.err || m_user !== e.user) begin
          bad++;
          $display("FAIL result #%0d: got u=%0d v=%0d err=%0b user=%0d expected u=%0d v=%0d err=%0b user=%0d",
                   txn_n, $signed(m_fixed_u), $signed(m_fixed_v), m_range_error, m_user,
                   $signed(e.u), $signed(e.v), e.err, e.user);
        end else begin
          $display("txn %0d: u=%0d v=%0d err=%0b user=%0d ok", txn_n,
                   $signed(m_fixed_u), $signed(m_fixed_v), m_range_error, m_user);
        end
      end
    end
  end

  // Present one input and wait (bounded) for its accept edge.
  task automatic send(input logic [SW-1:0] x, input logic [SW-1:0] y,
                      input logic [SW-1:0] z, input logic [UW-1:0] user, output exp_t e);
    int guard = 0;
    logic acc = 1'b0;
    e = model(x, y, z, user);
    s_fixed_x = x; s_fixed_y = y; s_fixed_z = z; s_user = user; s_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_ready && cke && !reset;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    else exp_q.push_back(e);
  endtask

  // Count edges (accept edge = 1) until m_valid; optionally drop cke for 3 edges.
  task automatic wait_valid(input int cke_off_at, output int lat);
    lat = 1;
    while (!m_valid && lat < 300) begin
      if (lat == cke_off_at) cke = 1'b0;
      if (lat == cke_off_at + 3) cke = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    cke = 1'b1;
    if (!m_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) check("drain_timeout", 0, 1);
  endtask

  task automatic run(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic [SW-1:0] z,
                     input logic [UW-1:0] user, input int cke_off_at, input int exp_lat, output exp_t e);
    int lat;
    send(x, y, z, user, e);
    wait_valid(cke_off_at, lat);
    check("latency", lat, exp_lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_u", m_fixed_u, 0);
    check("reset_m_v", m_fixed_v, 0);
    check("reset_err", m_range_error, 0);
    check("reset_user", m_user, 0);
    check("reset_s_ready", s_ready, 0);
    reset = 1'b0;
    #1;
    check("idle_s_ready", s_ready, 1);

    // Basic divide with both signs.
    run(25'sd768, -25'sd384, 25'sd512, 4'd1, -10, 21, e);
    check("basic_u", $signed(m_fixed_u), 384);
    check("basic_v", $signed(m_fixed_v), -192);
    check("basic_err", m_range_error, 0);
    drain();

    // Truncation toward zero.
    run(25'sd256, -25'sd256, 25'sd768, 4'd2, -10, 21, e);
    check("trunc_u", $signed(m_fixed_u), 85);
    check("trunc_v", $signed(m_fixed_v), -85);
    drain();

    // Non-positive divisors.
    run(25'sd768, 25'sd100, 25'sd0, 4'd5, -10, 1, e);
    check("z0_err", m_range_error, 1);
    check("z0_user", m_user, 5);
    drain();
    run(25'sd768, 25'sd100, -25'sd512, 4'd5, -10, 1, e);
    check("zneg_err", m_range_error, 1);
    check("zneg_u", m_fixed_u, 0);
    drain();

    // Both quotients saturate.
    run(25'sd16777215, -25'sd16777215, 25'sd1, 4'd3, -10, 21, e);
    check("sat_u", $signed(m_fixed_u), 524287);
    check("sat_v", $signed(m_fixed_v), -524287);
    check("sat_err", m_range_error, 1);
    drain();

    // Zero numerator over the smallest divisor.
    run(25'sd0, 25'sd0, 25'sd1, 4'd4, -10, 21, e);
    check("zero_err", m_range_error, 0);
    drain();

    // Back-pressure in DONE.
    m_ready = 1'b0;
    run(25'sd1000, -25'sd2000, 25'sd300, 4'd6, -10, 21, e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", m_valid, 1);
      check("hold_s_ready", s_ready, 0);
      check("hold_u", m_fixed_u, e.u);
      check("hold_v", m_fixed_v, e.v);
    end
    m_ready = 1'b1;
    drain();

    // cke dropped for 3 edges mid-divide.
    run(25'sd5000, 25'sd777, 25'sd999, 4'd7, 5, 24, e);
    drain();

    // Reset during CALC aborts the transaction.
    send(25'sd4096, 25'sd333, 25'sd17, 4'd8, e);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_back());
    check("abort_m_valid", m_valid, 0);
    check("abort_m_u", m_fixed_u, 0);
    check("abort_m_v", m_fixed_v, 0);
    reset = 1'b0;
    #1;
    check("abort_s_ready", s_ready, 1);
    repeat (25) begin @(posedge clk); #1; check("abort_quiet", m_valid, 0); end
    run(25'sd4096, 25'sd333, 25'sd17, 4'd9, -10, 21, e);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      logic [SW-1:0] x, y, z;
      int exp_lat;
      x = SW'($signed(SW'($urandom)) >>> $urandom_range(0, 22));
      y = SW'($signed(SW'($urandom)) >>> $urandom_range(0, 22));
      if ($urandom_range(0, 7) == 0) z = SW'($signed(SW'($urandom)) >>> $urandom_range(0, 24)) | SW'(1 << (SW - 1));
      else if ($urandom_range(0, 15) == 0) z = '0;
      else z = SW'(1 + ($urandom % (1 << $urandom_range(1, 23))));
      exp_lat = ($signed(z) <= 0) ? 1 : 21;
      m_ready = ($urandom_range(0, 3) != 0);
      run(x, y, z, 4'($urandom), -10, exp_lat, e);
      if (!m_ready) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        m_ready = 1'b1;
      end
      drain();
    end

    drain();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
